// File: rtl/qrisc32_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// qrisc32_dmem_arbiter
//
// Purpose
//   Shares one single-ported, Avalon-style data SRAM between three qrisc32
//   masters:
//     M0 : data write        (MEM stage)
//     M1 : data read         (MEM stage)
//     M2 : instruction fetch
//   One command is registered onto the slave bus per cycle. The grant stays
//   locked while the slave stalls. Read data comes back READ_LAT cycles after
//   acceptance, and it is tagged to the master that issued the read.
//
// Configuration
//   QRISC32_ARB_RR_EN  defined     : round-robin arbitration among M0..M2.
//                      not defined : fixed priority M0 > M1 > M2 (default).
//
// Parameters
//   AW        address width
//   DW        data width
//   READ_LAT  slave read latency, accepted s_rd -> valid s_data_r (1..4)
//
// Ports
//   clk, reset                   rising-edge clock, synchronous active-high reset
//   m0_address/m0_wr/m0_data_w   M0 write command
//   m1_address/m1_rd             M1 read command
//   m2_address/m2_rd             M2 read command
//   mN_wait_req                  1 = command not accepted yet (master holds it)
//   m1_data_r/m1_rdvalid         M1 read return (data is zero when not valid)
//   m2_data_r/m2_rdvalid         M2 read return (data is zero when not valid)
//   s_address/s_rd/s_wr/s_data_w registered slave command
//   s_wait_req                   slave stall; s_* is frozen while it is high
//   s_data_r                     slave read data
// -----------------------------------------------------------------------------
module qrisc32_dmem_arbiter #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int READ_LAT = 2
) (
   input  logic          clk,
   input  logic          reset,
   // M0: data write
   input  logic [AW-1:0] m0_address,
   input  logic          m0_wr,
   input  logic [DW-1:0] m0_data_w,
   output logic          m0_wait_req,
   // M1: data read
   input  logic [AW-1:0] m1_address,
   input  logic          m1_rd,
   output logic          m1_wait_req,
   output logic [DW-1:0] m1_data_r,
   output logic          m1_rdvalid,
   // M2: instruction fetch
   input  logic [AW-1:0] m2_address,
   input  logic          m2_rd,
   output logic          m2_wait_req,
   output logic [DW-1:0] m2_data_r,
   output logic          m2_rdvalid,
   // shared slave
   output logic [AW-1:0] s_address,
   output logic          s_rd,
   output logic          s_wr,
   output logic [DW-1:0] s_data_w,
   input  logic          s_wait_req,
   input  logic [DW-1:0] s_data_r
);

   typedef enum logic {
      ST_IDLE,    // nothing on s_*
      ST_ISSUE    // a command is registered on s_*
   } state_t;

   localparam logic [1:0] M0 = 2'd0;
   localparam logic [1:0] M1 = 2'd1;
   localparam logic [1:0] M2 = 2'd2;

   state_t          r_state;
   state_t          w_state_next;
   logic [1:0]      r_grant;
   logic [AW-1:0]   r_s_address;
   logic            r_s_rd;
   logic            r_s_wr;
   logic [DW-1:0]   r_s_data_w;

   logic [2:0]      w_req;
   logic [2:0]      w_grant_oh;
   logic [2:0]      w_req_eff;
   logic            w_accept;
   logic            w_can_issue;
   logic [1:0]      w_sel;
   logic            w_sel_vld;
   logic [AW-1:0]   w_sel_addr;

   logic [READ_LAT-1:0] r_pipe_vld;
   logic [READ_LAT-1:0] r_pipe_tag;   // 0 = M1, 1 = M2
   logic            w_push_vld;
   logic            w_push_tag;
   logic            w_ret_vld;
   logic            w_ret_tag;

   // --------------------------------------------------------------------------
   // Request vector and acceptance
   // --------------------------------------------------------------------------
   assign w_req      = {m2_rd, m1_rd, m0_wr};
   assign w_grant_oh = 3'b001 << r_grant;

   // The slave takes the command on s_* in any ISSUE cycle where it does not stall.
   assign w_accept    = (r_state == ST_ISSUE) && !s_wait_req && !reset;
   assign w_can_issue = (r_state == ST_IDLE) || w_accept;

   // The master being accepted still shows its request this cycle. It only
   // drops the request on the next cycle, so it is masked out of
   // re-arbitration here. Without the mask the same command would be
   // issued twice.
   assign w_req_eff = w_req & ~(w_accept ? w_grant_oh : 3'b000);

   // --------------------------------------------------------------------------
   // Arbitration
   // --------------------------------------------------------------------------
`ifdef QRISC32_ARB_RR_EN
   logic [1:0] r_rr_ptr;
   logic [1:0] w_ptr_eff;

   function automatic logic [1:0] f_inc3(input logic [1:0] x);
      return (x == M2) ? M0 : x + 2'd1;
   endfunction

   // On an acceptance, the pointer is about to move past the granted master.
   // Searching from that future value now keeps the rotation gap-free.
   assign w_ptr_eff = w_accept ? f_inc3(r_grant) : r_rr_ptr;

   always_comb begin
      logic [1:0] v_idx;
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_sel     = M0;
      w_sel_vld = 1'b0;
      v_idx     = w_ptr_eff;
      for (int k = 0; k < 3; k++) begin
         if (!w_sel_vld && w_req_eff[v_idx]) begin
            w_sel     = v_idx;
            w_sel_vld = 1'b1;
         end
         v_idx = f_inc3(v_idx);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rr_ptr <= M0;
      end else if (w_accept) begin
         r_rr_ptr <= f_inc3(r_grant);
      end
   end
`else
   // Fixed priority. M0 ranks first, so a write and a read to the same
   // address in the same cycle resolve write-first. The read then returns
   // the new data.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_sel     = M0;
      w_sel_vld = 1'b1;
      if (w_req_eff[0]) begin
         w_sel = M0;
      end else if (w_req_eff[1]) begin
         w_sel = M1;
      end else if (w_req_eff[2]) begin
         w_sel = M2;
      end else begin
         w_sel_vld = 1'b0;
      end
   end
`endif

   always_comb begin
      w_sel_addr = m0_address;
      case (w_sel)
         M1:      w_sel_addr = m1_address;
         M2:      w_sel_addr = m2_address;
         default: w_sel_addr = m0_address;
      endcase
   end

   // --------------------------------------------------------------------------
   // FSM: state register + next-state logic
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_sel_vld) begin
               w_state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // A stall holds ISSUE with the grant locked. On acceptance,
            // the next command follows immediately if any request is left.
            if (!s_wait_req) begin
               w_state_next = w_sel_vld ? ST_ISSUE : ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // --------------------------------------------------------------------------
   // Registered slave command. It loads only when the bus is free or the
   // current command is being accepted, so it stays frozen during a stall.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_grant     <= M0;
         r_s_address <= '0;
         r_s_rd      <= 1'b0;
         r_s_wr      <= 1'b0;
         r_s_data_w  <= '0;
      end else if (w_can_issue) begin
         if (w_sel_vld) begin
            r_grant     <= w_sel;
            r_s_address <= w_sel_addr;
            r_s_rd      <= (w_sel != M0);
            r_s_wr      <= (w_sel == M0);
            if (w_sel == M0) begin
               r_s_data_w <= m0_data_w;
            end
         end else begin
            r_s_rd <= 1'b0;
            r_s_wr <= 1'b0;
         end
      end
   end

   assign s_address = r_s_address;
   assign s_rd      = r_s_rd;
   assign s_wr      = r_s_wr;
   assign s_data_w  = r_s_data_w;

   // --------------------------------------------------------------------------
   // Master handshake. wait_req is low only in the exact cycle this master's
   // command is accepted. It stays combinationally high while reset holds the
   // FSM idle.
   // --------------------------------------------------------------------------
   assign m0_wait_req = m0_wr & ~(w_accept & (r_grant == M0));
   assign m1_wait_req = m1_rd & ~(w_accept & (r_grant == M1));
   assign m2_wait_req = m2_rd & ~(w_accept & (r_grant == M2));

   // --------------------------------------------------------------------------
   // Read-return tag pipe. Every acceptance pushes one entry. Writes and
   // idle cycles push valid=0. The last stage lines up with s_data_r
   // READ_LAT cycles after acceptance.
   // --------------------------------------------------------------------------
   assign w_push_vld = w_accept & r_s_rd;
   assign w_push_tag = (r_grant == M2);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pipe_vld <= '0;
         r_pipe_tag <= '0;
      end else begin
         r_pipe_vld[0] <= w_push_vld;
         r_pipe_tag[0] <= w_push_tag;
         for (int i = 1; i < READ_LAT; i++) begin
            r_pipe_vld[i] <= r_pipe_vld[i-1];
            r_pipe_tag[i] <= r_pipe_tag[i-1];
         end
      end
   end

   assign w_ret_vld  = r_pipe_vld[READ_LAT-1];
   assign w_ret_tag  = r_pipe_tag[READ_LAT-1];
   assign m1_rdvalid = w_ret_vld & ~w_ret_tag;
   assign m2_rdvalid = w_ret_vld &  w_ret_tag;

   // Data is gated to zero outside its valid pulse. This way neither master
   // ever sees stale or foreign read data.
   assign m1_data_r = m1_rdvalid ? s_data_r : '0;
   assign m2_data_r = m2_rdvalid ? s_data_r : '0;

endmodule

// File: tb/tb_qrisc32_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_qrisc32_dmem_arbiter
//
// Directed self-checking bench for qrisc32_dmem_arbiter with READ_LAT=2.
// A small behavioural SRAM answers reads two cycles after acceptance.
// Inputs are driven 1 ns after the rising edge. Outputs are checked 1 ns
// later, away from the edge.
// -----------------------------------------------------------------------------
module tb_qrisc32_dmem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] m0_address, m1_address, m2_address;
   logic          m0_wr, m1_rd, m2_rd;
   logic [DW-1:0] m0_data_w;
   logic          m0_wait_req, m1_wait_req, m2_wait_req;
   logic [DW-1:0] m1_data_r, m2_data_r;
   logic          m1_rdvalid, m2_rdvalid;
   logic [AW-1:0] s_address;
   logic          s_rd, s_wr;
   logic [DW-1:0] s_data_w;
   logic          s_wait_req;
   logic [DW-1:0] s_data_r;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   qrisc32_dmem_arbiter #(.AW(AW), .DW(DW), .READ_LAT(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .m0_address  (m0_address),
      .m0_wr       (m0_wr),
      .m0_data_w   (m0_data_w),
      .m0_wait_req (m0_wait_req),
      .m1_address  (m1_address),
      .m1_rd       (m1_rd),
      .m1_wait_req (m1_wait_req),
      .m1_data_r   (m1_data_r),
      .m1_rdvalid  (m1_rdvalid),
      .m2_address  (m2_address),
      .m2_rd       (m2_rd),
      .m2_wait_req (m2_wait_req),
      .m2_data_r   (m2_data_r),
      .m2_rdvalid  (m2_rdvalid),
      .s_address   (s_address),
      .s_rd        (s_rd),
      .s_wr        (s_wr),
      .s_data_w    (s_data_w),
      .s_wait_req  (s_wait_req),
      .s_data_r    (s_data_r)
   );

   // Behavioural SRAM: 256 words indexed by address[7:0], 2-cycle read latency.
   logic [31:0] mem [0:255];
   logic [31:0] rd_pipe0, rd_pipe1;

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
         mem[8'h40] <= 32'hDEAD_BEEF;
         mem[8'h44] <= 32'h0BAD_0044;
         mem[8'h80] <= 32'hCAFE_0080;
      end else if (s_wr && !s_wait_req) begin
         mem[s_address[7:0]] <= s_data_w;
      end
      rd_pipe0 <= (s_rd && !s_wait_req) ? mem[s_address[7:0]] : 32'h0;
      rd_pipe1 <= rd_pipe0;
   end
   assign s_data_r = rd_pipe1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   // Address used by each master in the contention test, in expected grant order.
   function automatic logic [31:0] exp_grant_addr(input int k);
`ifdef QRISC32_ARB_RR_EN
      case (k % 3)
         0:       return 32'h10;
         1:       return 32'h44;
         default: return 32'h80;
      endcase
`else
      return (k % 2 == 0) ? 32'h10 : 32'h44;
`endif
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ea;
      reset      = 1'b1;
      m0_address = '0; m1_address = '0; m2_address = '0;
      m0_wr = 1'b0; m1_rd = 1'b0; m2_rd = 1'b0;
      m0_data_w  = '0;
      s_wait_req = 1'b0;

      // ---------------- reset state ----------------
      tick(); tick();
      m2_rd = 1'b1; m2_address = 32'h80;
      settle();
      check("rst_s_rd", {31'b0, s_rd}, 32'd0);
      check("rst_s_wr", {31'b0, s_wr}, 32'd0);
      check("rst_s_addr", s_address, 32'h0);
      check("rst_m2_wait", {31'b0, m2_wait_req}, 32'd1);
      tick();
      check("rst_m2_wait_hold", {31'b0, m2_wait_req}, 32'd1);
      check("rst_rdvalid", {30'b0, m1_rdvalid, m2_rdvalid}, 32'd0);
      m2_rd = 1'b0;
      reset = 1'b0;
      tick();

      // ---------------- single read ----------------
      m1_rd = 1'b1; m1_address = 32'h40;                // c0
      settle();
      check("rd_wait_c0", {31'b0, m1_wait_req}, 32'd1);
      check("rd_s_rd_c0", {31'b0, s_rd}, 32'd0);
      tick();                                            // c1: accepted
      check("rd_s_rd_c1", {31'b0, s_rd}, 32'd1);
      check("rd_s_addr_c1", s_address, 32'h40);
      check("rd_wait_c1", {31'b0, m1_wait_req}, 32'd0);
      tick();                                            // c2
      m1_rd = 1'b0;
      settle();
      check("rd_s_rd_c2", {31'b0, s_rd}, 32'd0);
      check("rd_valid_c2", {31'b0, m1_rdvalid}, 32'd0);
      tick();                                            // c3: return
      check("rd_valid_c3", {31'b0, m1_rdvalid}, 32'd1);
      check("rd_data_c3", m1_data_r, 32'hDEAD_BEEF);
      check("rd_m2valid_c3", {31'b0, m2_rdvalid}, 32'd0);
      tick();
      check("rd_valid_c4", {31'b0, m1_rdvalid}, 32'd0);
      do_reset();

      // ---------------- write/read collision ----------------
      m0_wr = 1'b1; m0_address = 32'h10; m0_data_w = 32'h1234;
      m1_rd = 1'b1; m1_address = 32'h10;                // c0
      settle();
      check("col_w0_c0", {31'b0, m0_wait_req}, 32'd1);
      tick();                                            // c1: write
      check("col_s_wr_c1", {31'b0, s_wr}, 32'd1);
      check("col_s_rd_c1", {31'b0, s_rd}, 32'd0);
      check("col_s_dw_c1", s_data_w, 32'h1234);
      check("col_w0_c1", {31'b0, m0_wait_req}, 32'd0);
      check("col_w1_c1", {31'b0, m1_wait_req}, 32'd1);
      tick();                                            // c2: read
      m0_wr = 1'b0;
      settle();
      check("col_s_rd_c2", {31'b0, s_rd}, 32'd1);
      check("col_s_wr_c2", {31'b0, s_wr}, 32'd0);
      check("col_s_addr_c2", s_address, 32'h10);
      check("col_w1_c2", {31'b0, m1_wait_req}, 32'd0);
      tick();                                            // c3
      m1_rd = 1'b0;
      settle();
      check("col_valid_c3", {31'b0, m1_rdvalid}, 32'd0);
      tick();                                            // c4: return
      check("col_valid_c4", {31'b0, m1_rdvalid}, 32'd1);
      check("col_data_c4", m1_data_r, 32'h1234);
      tick();
      do_reset();

      // ---------------- slave stall during fetch ----------------
      m2_rd = 1'b1; m2_address = 32'h80; s_wait_req = 1'b1;   // c0
      tick();                                                  // c1..c3 stalled
      m1_rd = 1'b1; m1_address = 32'h44;
      for (int c = 1; c <= 3; c++) begin
         settle();
         check("stl_s_addr", s_address, 32'h80);
         check("stl_s_rd", {31'b0, s_rd}, 32'd1);
         check("stl_w2", {31'b0, m2_wait_req}, 32'd1);
         check("stl_w1", {31'b0, m1_wait_req}, 32'd1);
         tick();
      end
      s_wait_req = 1'b0;                                       // c4: release
      settle();
      check("stl_rel_w2", {31'b0, m2_wait_req}, 32'd0);
      check("stl_rel_w1", {31'b0, m1_wait_req}, 32'd1);
      check("stl_rel_addr", s_address, 32'h80);
      tick();                                                  // c5: m1 issued
      m2_rd = 1'b0;
      settle();
      check("stl_m1_addr", s_address, 32'h44);
      check("stl_m1_rd", {31'b0, s_rd}, 32'd1);
      check("stl_m1_w1", {31'b0, m1_wait_req}, 32'd0);
      tick();                                                  // c6: m2 return
      m1_rd = 1'b0;
      settle();
      check("stl_m2_valid", {31'b0, m2_rdvalid}, 32'd1);
      check("stl_m2_data", m2_data_r, 32'hCAFE_0080);
      check("stl_m1_valid_c6", {31'b0, m1_rdvalid}, 32'd0);
      tick();                                                  // c7: m1 return
      check("stl_m1_valid", {31'b0, m1_rdvalid}, 32'd1);
      check("stl_m1_data", m1_data_r, 32'h0BAD_0044);
      check("stl_m2_valid_c7", {31'b0, m2_rdvalid}, 32'd0);
      tick();
      do_reset();

      // ---------------- back-to-back reads ----------------
      m1_rd = 1'b1; m1_address = 32'h40;
      m2_rd = 1'b1; m2_address = 32'h80;                // c0
      tick();                                            // c1: M1
      check("b2b_addr_c1", s_address, 32'h40);
      check("b2b_rd_c1", {31'b0, s_rd}, 32'd1);
      check("b2b_w2_c1", {31'b0, m2_wait_req}, 32'd1);
      tick();                                            // c2: M2
      m1_rd = 1'b0;
      settle();
      check("b2b_addr_c2", s_address, 32'h80);
      check("b2b_rd_c2", {31'b0, s_rd}, 32'd1);
      check("b2b_w2_c2", {31'b0, m2_wait_req}, 32'd0);
      tick();                                            // c3
      m2_rd = 1'b0;
      settle();
      check("b2b_rd_c3", {31'b0, s_rd}, 32'd0);
      check("b2b_v1_c3", {31'b0, m1_rdvalid}, 32'd1);
      check("b2b_d1_c3", m1_data_r, 32'hDEAD_BEEF);
      check("b2b_v2_c3", {31'b0, m2_rdvalid}, 32'd0);
      tick();                                            // c4
      check("b2b_v2_c4", {31'b0, m2_rdvalid}, 32'd1);
      check("b2b_d2_c4", m2_data_r, 32'hCAFE_0080);
      check("b2b_v1_c4", {31'b0, m1_rdvalid}, 32'd0);
      tick();
      do_reset();

      // ---------------- reset mid-read ----------------
      m1_rd = 1'b1; m1_address = 32'h40;                // c0
      tick();                                            // c1: accepted
      check("rmr_w1_c1", {31'b0, m1_wait_req}, 32'd0);
      tick();                                            // c2: reset asserted
      m1_rd = 1'b0; reset = 1'b1;
      tick();                                            // c3: in reset
      m1_rd = 1'b1;
      settle();
      check("rmr_v1_c3", {31'b0, m1_rdvalid}, 32'd0);
      check("rmr_s_rd_c3", {31'b0, s_rd}, 32'd0);
      check("rmr_s_addr_c3", s_address, 32'h0);
      check("rmr_w1_c3", {31'b0, m1_wait_req}, 32'd1);
      tick();                                            // c4
      m1_rd = 1'b0; reset = 1'b0;
      settle();
      check("rmr_v1_c4", {31'b0, m1_rdvalid}, 32'd0);
      tick();                                            // c5
      check("rmr_v_c5", {30'b0, m1_rdvalid, m2_rdvalid}, 32'd0);
      check("rmr_s_rd_c5", {31'b0, s_rd}, 32'd0);
      tick();

      // ---------------- continuous contention ----------------
      m0_wr = 1'b1; m0_address = 32'h10; m0_data_w = 32'h5555;
      m1_rd = 1'b1; m1_address = 32'h44;
      m2_rd = 1'b1; m2_address = 32'h80;
      for (int k = 0; k < 6; k++) begin
         tick();
         ea = exp_grant_addr(k);
         check("arb_addr", s_address, ea);
         check("arb_s_wr", {31'b0, s_wr}, {31'b0, ea == 32'h10});
         check("arb_w0", {31'b0, m0_wait_req}, {31'b0, ea != 32'h10});
         check("arb_w1", {31'b0, m1_wait_req}, {31'b0, ea != 32'h44});
         check("arb_w2", {31'b0, m2_wait_req}, {31'b0, ea != 32'h80});
      end
      m0_wr = 1'b0; m1_rd = 1'b0; m2_rd = 1'b0;
      tick(); tick(); tick();
      check("arb_drain_s_rd", {31'b0, s_rd}, 32'd0);
      check("arb_drain_v", {30'b0, m1_rdvalid, m2_rdvalid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
